// File: rtl/ahb_protocol_checker.sv
// ahb_protocol_checker
//
// Passive AHB-Lite protocol checker. Samples one master-slave interface on
// every rising HCLK edge and evaluates eight protocol rules in parallel:
//   0 SEQ_ORDER  SEQ/BUSY accepted with no burst in progress
//   1 HOLD       address-phase signals changed while HREADY was low
//   2 ADDR       SEQ address/size/burst differs from the expected beat
//   3 BURST_LEN  fixed-length burst cut short by NONSEQ/IDLE
//   4 WAIT_TO    HREADY low for more than MAX_WAIT consecutive cycles
//   5 BUSY_TO    more than MAX_BUSY consecutive accepted BUSY beats
//   6 RESP       ERROR response not following the two-cycle rule
//   7 ALIGN      active transfer misaligned to its size, or HSIZE > 3
//
// Ports:
//   HCLK, HRESET          bus clock, asynchronous active-high reset
//   HTRANS .. HRESP       sampled AHB-Lite signals
//   check_en[7:0]         per-check enable (masks the raw check results)
//   clr                   synchronous clear of all reporting state
//   err_flags[7:0]        sticky per-check violation flags
//   err_pulse             high for the cycle after any violating sample
//   err_first_id[2:0]     lowest check index of the first violating sample
//   err_first_vld         err_first_id holds a valid index
//   err_count[CNT_W-1:0]  saturating count of violating samples

module ahb_protocol_checker #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned MAX_BUSY = 6,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [1:0]        HTRANS,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [7:0]        check_en,
  input  logic              clr,
  output logic [7:0]        err_flags,
  output logic              err_pulse,
  output logic [2:0]        err_first_id,
  output logic              err_first_vld,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    B_IDLE,
    B_BURST
  } bstate_t;

  localparam logic [2:0]        HB_SINGLE = 3'b000;
  localparam logic [2:0]        HB_INCR   = 3'b001;
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [7:0]        WAIT_LIM  = 8'(MAX_WAIT);
  localparam logic [7:0]        BUSY_LIM  = 8'(MAX_BUSY);

  // Burst tracking state
  bstate_t           state;
  logic [2:0]        cap_burst;
  logic [2:0]        cap_size;
  logic [ADDR_W-1:0] exp_addr;
  logic [3:0]        beats_rem;

  // Previous-edge samples
  logic [1:0]        prev_htrans;
  logic [ADDR_W-1:0] prev_haddr;
  logic              prev_hwrite;
  logic [2:0]        prev_hsize;
  logic [2:0]        prev_hburst;
  logic              prev_hready;
  logic              prev_hresp;

  // Stall / busy counters
  logic [7:0]        wait_cnt;
  logic              wait_fired;
  logic [7:0]        busy_cnt;
  logic              busy_fired;

  // Combinational helpers
  htrans_t           tr;
  logic              accept;
  logic              is_active;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] addr_inc;
  logic [2:0]        wrap_sh;
  logic [ADDR_W-1:0] wrap_mask;
  logic              is_wrap;
  logic [ADDR_W-1:0] next_addr;
  logic [3:0]        len_m1;
  logic [7:0]        low_mask;
  logic              fixed_len;
  logic [7:0]        chk;
  logic [7:0]        viol;

  // Reporting state after an optional clear, before this sample's violations
  logic [7:0]        flags_base;
  logic [CNT_W-1:0]  cnt_base;
  logic [2:0]        id_base;
  logic              vld_base;

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    low_idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (v[i-1]) low_idx = 3'(i - 1);
    end
  endfunction

  always_comb begin
    tr        = htrans_t'(HTRANS);
    accept    = HREADY;
    is_active = (tr == TR_NONSEQ) || (tr == TR_SEQ);
    incr      = ONE << HSIZE;
    addr_inc  = HADDR + incr;
    // Wrap boundary is len*incr; len = 4/8/16 maps to a shift of 2/3/4.
    wrap_sh   = {1'b0, HBURST[2:1]} + 3'd1;
    wrap_mask = (incr << wrap_sh) - ONE;
    is_wrap   = !HBURST[0] && (HBURST != HB_SINGLE);
    next_addr = is_wrap ? ((HADDR & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
    case (HBURST[2:1])
      2'b01:   len_m1 = 4'd3;
      2'b10:   len_m1 = 4'd7;
      2'b11:   len_m1 = 4'd15;
      default: len_m1 = 4'd0;
    endcase
    low_mask  = incr[7:0] - 8'd1;
    fixed_len = (cap_burst != HB_INCR);
  end

  always_comb begin
    chk    = '0;
    chk[0] = accept && ((tr == TR_SEQ) || (tr == TR_BUSY)) && (state == B_IDLE);
    chk[1] = !prev_hready && prev_htrans[1] &&
             ((HTRANS != prev_htrans) || (HADDR != prev_haddr) ||
              (HWRITE != prev_hwrite) || (HSIZE != prev_hsize) ||
              (HBURST != prev_hburst));
    chk[2] = accept && (tr == TR_SEQ) && (state == B_BURST) &&
             ((HADDR != exp_addr) || (HSIZE != cap_size) || (HBURST != cap_burst));
    chk[3] = accept && ((tr == TR_NONSEQ) || (tr == TR_IDLE)) && (state == B_BURST) &&
             fixed_len && (beats_rem != 4'd0);
    chk[4] = !HREADY && (wait_cnt == WAIT_LIM) && !wait_fired;
    chk[5] = accept && (tr == TR_BUSY) && (busy_cnt == BUSY_LIM) && !busy_fired;
    chk[6] = (HRESP && HREADY && !(prev_hresp && !prev_hready)) ||
             (prev_hresp && !prev_hready && !HRESP);
    chk[7] = accept && is_active && ((|(HADDR[7:0] & low_mask)) || HSIZE[2]);
    viol   = chk & check_en;
  end

  // Burst FSM with captured burst attributes and expected next address
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= B_IDLE;
      cap_burst <= '0;
      cap_size  <= '0;
      exp_addr  <= '0;
      beats_rem <= '0;
    end else if (accept) begin
      case (tr)
        TR_NONSEQ: begin
          cap_burst <= HBURST;
          cap_size  <= HSIZE;
          exp_addr  <= next_addr;
          beats_rem <= len_m1;
          state     <= (HBURST == HB_SINGLE) ? B_IDLE : B_BURST;
        end
        TR_SEQ: begin
          exp_addr <= next_addr;
          if ((state == B_BURST) && fixed_len) begin
            beats_rem <= beats_rem - 4'd1;
            if (beats_rem == 4'd1) state <= B_IDLE;
          end
        end
        TR_IDLE: state <= B_IDLE;
        default: ;
      endcase
    end
  end

  // Previous-edge samples and the stall/busy counters
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      prev_htrans <= '0;
      prev_haddr  <= '0;
      prev_hwrite <= 1'b0;
      prev_hsize  <= '0;
      prev_hburst <= '0;
      prev_hready <= 1'b1;
      prev_hresp  <= 1'b0;
      wait_cnt    <= '0;
      wait_fired  <= 1'b0;
      busy_cnt    <= '0;
      busy_fired  <= 1'b0;
    end else begin
      prev_htrans <= HTRANS;
      prev_haddr  <= HADDR;
      prev_hwrite <= HWRITE;
      prev_hsize  <= HSIZE;
      prev_hburst <= HBURST;
      prev_hready <= HREADY;
      prev_hresp  <= HRESP;

      // The fired flags keep each timeout to one report per stall/busy run,
      // even once the counter has saturated.
      if (!HREADY) begin
        wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        if (chk[4]) wait_fired <= 1'b1;
      end else begin
        wait_cnt   <= '0;
        wait_fired <= 1'b0;
      end

      if (accept) begin
        if (tr == TR_BUSY) begin
          busy_cnt <= (busy_cnt == 8'hFF) ? busy_cnt : busy_cnt + 8'd1;
          if (chk[5]) busy_fired <= 1'b1;
        end else begin
          busy_cnt   <= '0;
          busy_fired <= 1'b0;
        end
      end
    end
  end

  // clr clears first, then this sample's violations are applied on top.
  always_comb begin
    flags_base = clr ? '0 : err_flags;
    cnt_base   = clr ? '0 : err_count;
    id_base    = clr ? '0 : err_first_id;
    vld_base   = clr ? 1'b0 : err_first_vld;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_flags     <= '0;
      err_pulse     <= 1'b0;
      err_first_id  <= '0;
      err_first_vld <= 1'b0;
      err_count     <= '0;
    end else begin
      err_flags <= flags_base | viol;
      err_pulse <= |viol;
      if (|viol) begin
        err_count <= (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
        if (!vld_base) begin
          err_first_id  <= low_idx(viol);
          err_first_vld <= 1'b1;
        end else begin
          err_first_id  <= id_base;
          err_first_vld <= vld_base;
        end
      end else begin
        err_count     <= cnt_base;
        err_first_id  <= id_base;
        err_first_vld <= vld_base;
      end
    end
  end

endmodule
